// File: rtl/imem_refill_responder.sv
// Instruction-store responder for L1 I-cache refills: one request at a time,
// fixed latency, returns the aligned 64-bit line plus the requested word.
// state   | meaning
// IDLE    | waiting for a refill request
// WAIT    | latency countdown on the latched line
// RESPOND | outputs loaded; completion pulse issued on exit
module imem_refill_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 4,
  parameter logic [31:0] NOP_WORD    = 32'h00000033
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instructionRequest,
  input  logic [31:0] instructionAddress,
  output logic        receivedInstruction,
  output logic [63:0] cacheData,
  output logic [31:0] instruction,
  output logic        busy,
  input  logic        progWrite,
  input  logic [31:0] progAddress,
  input  logic [31:0] progData,
  output logic [15:0] servedCount
);
  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  state_t      state_q, state_d;
  logic [28:0] line_q, line_d;
  logic        sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        recv_q, recv_d;
  logic        busy_q, busy_d;
  logic [63:0] cache_q, cache_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] served_q, served_d;

  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY=1 the load happens at the accepting edge, so read from the live address.
  logic [28:0] rd_line;
  logic        rd_sel;
  logic [29:0] idx_lo, idx_hi;
  logic [31:0] word_lo, word_hi;
  logic [29:0] prog_idx;
  logic        unused_bits;

  assign rd_line     = (state_q == S_IDLE) ? instructionAddress[31:3] : line_q;
  assign rd_sel      = (state_q == S_IDLE) ? instructionAddress[2] : sel_q;
  assign idx_lo      = {rd_line, 1'b0};
  assign idx_hi      = {rd_line, 1'b1};
  assign word_lo     = ({2'b00, idx_lo} < DEPTH_U) ? mem[idx_lo[AW-1:0]] : NOP_WORD;
  assign word_hi     = ({2'b00, idx_hi} < DEPTH_U) ? mem[idx_hi[AW-1:0]] : NOP_WORD;
  assign prog_idx    = progAddress[31:2];
  assign unused_bits = &{1'b0, progAddress[1:0], instructionAddress[1:0]};

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    recv_d   = 1'b0;
    cache_d  = cache_q;
    instr_d  = instr_q;
    served_d = served_q;
    case (state_q)
      S_IDLE: begin
        if (instructionRequest) begin
          line_d = instructionAddress[31:3];
          sel_d  = instructionAddress[2];
          if (LATENCY > 1) begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end else begin
            cache_d = {word_hi, word_lo};
            instr_d = rd_sel ? word_hi : word_lo;
            state_d = S_RESPOND;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          cache_d = {word_hi, word_lo};
          instr_d = rd_sel ? word_hi : word_lo;
          state_d = S_RESPOND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESPOND: begin
        recv_d   = 1'b1;
        served_d = (served_q == 16'hFFFF) ? served_q : served_q + 16'd1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      recv_q   <= 1'b0;
      busy_q   <= 1'b0;
      cache_q  <= '0;
      instr_q  <= '0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      recv_q   <= recv_d;
      busy_q   <= busy_d;
      cache_q  <= cache_d;
      instr_q  <= instr_d;
      served_q <= served_d;
    end
  end

  // Store is deliberately not reset so a loaded program survives a reset.
  always_ff @(posedge clk) begin
    if (progWrite && ({2'b00, prog_idx} < DEPTH_U)) begin
      mem[prog_idx[AW-1:0]] <= progData;
    end
  end

  assign receivedInstruction = recv_q;
  assign busy                = busy_q;
  assign cacheData           = cache_q;
  assign instruction         = instr_q;
  assign servedCount         = served_q;
endmodule

// File: tb/tb_imem_refill_responder.sv
// Scoreboard bench for imem_refill_responder: one instance at LATENCY=4/1024 words,
// one at LATENCY=2/1023 words for the write race and the half-out-of-range line.
module tb_imem_refill_responder;
  localparam int LAT_A = 4;
  localparam int LAT_B = 2;

  typedef struct {
    int          cyc;
    logic [63:0] cache;
    logic [31:0] instr;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  logic        a_req_i = 1'b0, b_req_i = 1'b0;
  logic [31:0] a_addr = '0, b_addr = '0;
  logic        a_pw = 1'b0, b_pw = 1'b0;
  logic [31:0] a_pa = '0, b_pa = '0, a_pd = '0, b_pd = '0;
  logic        a_recv, b_recv, a_busy, b_busy;
  logic [63:0] a_cache, b_cache;
  logic [31:0] a_instr, b_instr;
  logic [15:0] a_cnt, b_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_refill_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(rst),
    .instructionRequest(a_req_i), .instructionAddress(a_addr),
    .receivedInstruction(a_recv), .cacheData(a_cache), .instruction(a_instr),
    .busy(a_busy), .progWrite(a_pw), .progAddress(a_pa), .progData(a_pd),
    .servedCount(a_cnt)
  );

  imem_refill_responder #(.DEPTH_WORDS(1023), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(rst),
    .instructionRequest(b_req_i), .instructionAddress(b_addr),
    .receivedInstruction(b_recv), .cacheData(b_cache), .instruction(b_instr),
    .busy(b_busy), .progWrite(b_pw), .progAddress(b_pa), .progData(b_pd),
    .servedCount(b_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every response pulse must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (a_recv) begin
      if (q_a.size() == 0) check("a_unexpected_pulse", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_pulse_cycle", 64'(cyc), 64'(e.cyc));
        check("a_cacheData", a_cache, e.cache);
        check("a_instruction", 64'(a_instr), 64'(e.instr));
        check("a_servedCount", 64'(a_cnt), 64'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (b_recv) begin
      if (q_b.size() == 0) check("b_unexpected_pulse", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_pulse_cycle", 64'(cyc), 64'(e.cyc));
        check("b_cacheData", b_cache, e.cache);
        check("b_instruction", 64'(b_instr), 64'(e.instr));
        check("b_servedCount", 64'(b_cnt), 64'(e.cnt));
      end
    end
  end

  task automatic drain(input bit which_b);
    for (int k = 0; k < 40; k++) begin
      if ((which_b ? q_b.size() : q_a.size()) == 0) break;
      @(negedge clk);
    end
    check(which_b ? "b_drain_timeout" : "a_drain_timeout",
          64'(which_b ? q_b.size() : q_a.size()), 64'd0);
    if (which_b) q_b.delete(); else q_a.delete();
  endtask

  task automatic a_prog(input logic [31:0] addr, input logic [31:0] data);
    a_pw = 1'b1; a_pa = addr; a_pd = data;
    @(negedge clk);
    a_pw = 1'b0;
  endtask

  task automatic b_prog(input logic [31:0] addr, input logic [31:0] data);
    b_pw = 1'b1; b_pa = addr; b_pd = data;
    @(negedge clk);
    b_pw = 1'b0;
  endtask

  task automatic a_req(input logic [31:0] addr, input logic [63:0] c,
                       input logic [31:0] i, input logic [15:0] n);
    a_req_i = 1'b1; a_addr = addr;
    @(negedge clk);
    a_req_i = 1'b0;
    q_a.push_back('{cyc + LAT_A, c, i, n});
    check("a_busy_after_accept", 64'(a_busy), 64'd1);
    drain(1'b0);
  endtask

  task automatic b_req(input logic [31:0] addr, input logic [63:0] c,
                       input logic [31:0] i, input logic [15:0] n, input bit race);
    b_req_i = 1'b1; b_addr = addr;
    @(negedge clk);
    b_req_i = 1'b0;
    q_b.push_back('{cyc + LAT_B, c, i, n});
    check("b_busy_after_accept", 64'(b_busy), 64'd1);
    if (race) b_prog(addr, 32'hDEADBEEF);
    drain(1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_recv", 64'(a_recv), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_cacheData", a_cache, 64'd0);
    check("rst_instruction", 64'(a_instr), 64'd0);
    check("rst_servedCount", 64'(a_cnt), 64'd0);

    a_prog(32'h100, 32'h00500093);
    a_prog(32'h104, 32'h00100113);
    a_prog(32'hFF8, 32'h0BADC0DE);
    a_prog(32'hFFC, 32'hCAFEF00D);
    a_prog(32'h1000, 32'h12345678);
    a_prog(32'h200, 32'h11111111);
    a_prog(32'h204, 32'h22222222);

    a_req(32'h100, 64'h00100113_00500093, 32'h00500093, 16'd1);
    a_req(32'h104, 64'h00100113_00500093, 32'h00100113, 16'd2);
    a_req(32'hFFC, 64'hCAFEF00D_0BADC0DE, 32'hCAFEF00D, 16'd3);
    a_req(32'h1000, 64'h00000033_00000033, 32'h00000033, 16'd4);
    a_req(32'h2000, 64'h00000033_00000033, 32'h00000033, 16'd5);
    a_req(32'hFFFF_FFFC, 64'h00000033_00000033, 32'h00000033, 16'd6);

    // Request held high across a busy window with the address changed mid-flight.
    a_req_i = 1'b1; a_addr = 32'h100;
    @(negedge clk);
    a_addr = 32'h200;
    q_a.push_back('{cyc + LAT_A, 64'h00100113_00500093, 32'h00500093, 16'd7});
    q_a.push_back('{cyc + LAT_A + 1 + LAT_A, 64'h22222222_11111111, 32'h11111111, 16'd8});
    check("a_busy_held_req", 64'(a_busy), 64'd1);
    repeat (LAT_A + 1) @(negedge clk);
    a_req_i = 1'b0;
    drain(1'b0);

    // Reset two cycles into WAIT: no pulse, counters cleared, store kept.
    a_req_i = 1'b1; a_addr = 32'h100;
    @(negedge clk);
    a_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(a_busy), 64'd0);
    check("abort_recv", 64'(a_recv), 64'd0);
    check("abort_servedCount", 64'(a_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_servedCount_after", 64'(a_cnt), 64'd0);
    a_req(32'h100, 64'h00100113_00500093, 32'h00500093, 16'd1);

    b_prog(32'h100, 32'h00500093);
    b_prog(32'h104, 32'h00100113);
    b_req(32'h100, 64'h00100113_00500093, 32'h00500093, 16'd1, 1'b1);
    b_req(32'h100, 64'h00100113_DEADBEEF, 32'hDEADBEEF, 16'd2, 1'b0);
    b_prog(32'hFF8, 32'hABCD0001);
    b_prog(32'hFFC, 32'h55555555);
    b_req(32'hFFC, 64'h00000033_ABCD0001, 32'h00000033, 16'd3, 1'b0);

    repeat (6) @(negedge clk);
    check("a_final_queue", 64'(q_a.size()), 64'd0);
    check("b_final_queue", 64'(q_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
